// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared FSM states, access size codes and misalignment rule
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam int TIMEOUT_DEFAULT = 16;

  // The illegal size code is reported through the misalign flag as well.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// rtl/mem_access_unit_lane_extract.sv - load lane select with sign/zero extension
module lane_extract
  import mem_access_unit_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_sign_ext,
  output logic [SIZE-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{(SIZE-8){i_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{(SIZE-16){i_sign_ext & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer: IDLE/REQ/RESP handshake with
// byte enables, lane replication, ack timeout and misalignment reporting
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_we,
  input  logic [1:0]      i_size,
  input  logic            i_sign_ext,
  input  logic [SIZE-1:0] i_addr,
  input  logic [SIZE-1:0] i_wdata,
  output logic            o_busy,
  output logic            o_done,
  output logic [SIZE-1:0] o_rdata,
  output logic            o_misalign,
  output logic            o_timeout,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [SIZE-1:0] o_mem_addr,
  output logic [SIZE-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_ack,
  input  logic [SIZE-1:0] i_mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_cnt;
  logic            r_misalign;
  logic            r_timeout;
  logic            r_mem_we;
  logic [3:0]      r_mem_be;
  logic [SIZE-1:0] r_mem_addr;
  logic [SIZE-1:0] r_mem_wdata;
  logic [SIZE-1:0] r_rdata;
  logic [1:0]      r_off;
  logic [1:0]      r_size;
  logic            r_sext;

  logic            w_misaligned;
  logic            w_expire;
  logic [3:0]      w_be;
  logic [SIZE-1:0] w_wdata;
  logic [SIZE-1:0] w_ext;

  assign w_misaligned = is_misaligned(i_size, i_addr[1:0]);
  assign w_expire     = (r_cnt == CNT_LAST);

  always_comb begin
    case (i_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
      end
    endcase
  end

  lane_extract #(.SIZE(SIZE)) u_lane_extract (
    .i_word     (i_mem_rdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_sign_ext (r_sext),
    .o_data     (w_ext)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    o_mem_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = w_misaligned ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        o_mem_req = 1'b1;
        // An ack on the final counted cycle still completes the access.
        if (i_mem_ack || w_expire) w_next = ST_RESP;
      end
      ST_RESP: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_misalign  <= 1'b0;
      r_timeout   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_sext      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && w_misaligned) begin
            r_misalign <= 1'b1;
          end else if (i_start) begin
            r_cnt       <= '0;
            r_mem_we    <= i_we;
            r_mem_be    <= w_be;
            r_mem_addr  <= {i_addr[SIZE-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_off       <= i_addr[1:0];
            r_size      <= i_size;
            r_sext      <= i_sign_ext;
          end
        end
        ST_REQ: begin
          if (i_mem_ack) begin
            if (!r_mem_we) r_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_expire) r_timeout <= 1'b1;
          end
        end
        ST_RESP: begin
          r_misalign <= 1'b0;
          r_timeout  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_rdata     = r_rdata;
  assign o_misalign  = r_misalign;
  assign o_timeout   = r_timeout;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        i_start, i_we, i_sign_ext, i_mem_ack;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic        o_busy, o_done, o_misalign, o_timeout, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_access_unit #(.SIZE(32), .TIMEOUT(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_we        (i_we),
    .i_size      (i_size),
    .i_sign_ext  (i_sign_ext),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_misalign  (o_misalign),
    .o_timeout   (o_timeout),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] addr, input logic [31:0] mr);
    int nbits;
    longint unsigned lane;
    nbits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    lane  = (longint'(mr) >> (8 * (addr % 4))) & ((64'd1 << nbits) - 1);
    if (sx && lane >= (64'd1 << (nbits - 1))) lane = lane - (64'd1 << nbits);
    return lane[31:0];
  endfunction

  task automatic run_access(input logic twe, input logic [1:0] tsz, input logic tsx,
                            input logic [31:0] taddr, input logic [31:0] twd,
                            input logic [31:0] tmr, input int tack);
    logic mis, exp_to;
    logic [3:0] ebe;
    logic [31:0] ewd;
    int cyc, reqcnt, exp_cyc;
    mis = (tsz == 2'd3) || (tsz == 2'd1 && taddr % 2 != 0) || (tsz == 2'd2 && taddr % 4 != 0);
    ebe = (tsz == 2'd0) ? 4'(1 << (taddr % 4)) : (tsz == 2'd1) ? 4'(3 << (taddr % 4)) : 4'hF;
    ewd = (tsz == 2'd0) ? 32'(twd[7:0]) * 32'h0101_0101 :
          (tsz == 2'd1) ? 32'(twd[15:0]) * 32'h0001_0001 : twd;
    i_start = 1'b1; i_we = twe; i_size = tsz; i_sign_ext = tsx; i_addr = taddr; i_wdata = twd;
    step();
    i_start = 1'b0;
    cyc = 1;
    if (mis) begin
      vectors++;
      if (o_done !== 1'b1 || o_misalign !== 1'b1 || o_timeout !== 1'b0 || o_mem_req !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL misalign_done addr=%h size=%0d: done=%b misalign=%b timeout=%b mem_req=%b busy=%b, required 1 1 0 0 1",
                 taddr, tsz, o_done, o_misalign, o_timeout, o_mem_req, o_busy);
      end
    end else begin
      exp_to  = !(tack >= 1 && tack <= TMO);
      exp_cyc = exp_to ? TMO + 1 : tack + 1;
      reqcnt  = 0;
      while (o_done !== 1'b1 && cyc <= TMO + 4) begin
        vectors++;
        if (o_mem_req !== 1'b1 || o_busy !== 1'b1 || o_mem_addr !== (taddr & ~32'h3) ||
            o_mem_be !== ebe || o_mem_wdata !== ewd || o_mem_we !== twe) begin
          errors++;
          $display("FAIL req_outputs cyc=%0d: req=%b busy=%b addr=%h be=%b wdata=%h we=%b, required 1 1 %h %b %h %b",
                   cyc, o_mem_req, o_busy, o_mem_addr, o_mem_be, o_mem_wdata, o_mem_we,
                   taddr & ~32'h3, ebe, ewd, twe);
        end
        reqcnt++;
        i_mem_ack   = (cyc == tack);
        i_mem_rdata = (cyc == tack) ? tmr : $urandom();
        i_start = 1'($urandom()); i_we = 1'($urandom()); i_size = 2'($urandom());
        i_sign_ext = 1'($urandom()); i_addr = $urandom(); i_wdata = $urandom();
        step();
        i_mem_ack = 1'b0;
        i_start   = 1'b0;
        cyc++;
      end
      if (!exp_to && !twe) exp_rdata = model_load(tsz, tsx, taddr, tmr);
      vectors++;
      if (cyc != exp_cyc || reqcnt != exp_cyc - 1) begin
        errors++;
        $display("FAIL latency addr=%h ack=%0d: done_cycle=%0d req_cycles=%0d, required %0d %0d",
                 taddr, tack, cyc, reqcnt, exp_cyc, exp_cyc - 1);
      end
      vectors++;
      if (o_done !== 1'b1 || o_timeout !== exp_to || o_misalign !== 1'b0 || o_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL completion addr=%h we=%b ack=%0d: done=%b timeout=%b misalign=%b rdata=%h, required 1 %b 0 %h",
                 taddr, twe, tack, o_done, o_timeout, o_misalign, o_rdata, exp_to, exp_rdata);
      end
    end
    i_start = 1'($urandom());
    step();
    i_start = 1'b0;
    vectors++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_misalign !== 1'b0 || o_timeout !== 1'b0 ||
        o_mem_req !== 1'b0 || o_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL back_to_idle: done=%b busy=%b misalign=%b timeout=%b req=%b rdata=%h, required 0 0 0 0 0 %h",
               o_done, o_busy, o_misalign, o_timeout, o_mem_req, o_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_start = 1'b0; i_we = 1'b0; i_size = 2'b00; i_sign_ext = 1'b0;
    i_addr = '0; i_wdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    step();
    step();
    vectors++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_misalign !== 1'b0 || o_timeout !== 1'b0 ||
        o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_be !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b mis=%b to=%b req=%b we=%b be=%b, required all 0",
               o_busy, o_done, o_misalign, o_timeout, o_mem_req, o_mem_we, o_mem_be);
    end
    vectors++;
    if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required 0 0 0", o_mem_addr, o_mem_wdata, o_rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_1234, 2);
    vectors++;
    if (exp_rdata !== 32'hFFFF_FF80 || o_rdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL load_byte_sext: rdata=%h, required ffffff80", o_rdata);
    end
    run_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h1111_2222, 3);
    vectors++;
    if (o_mem_addr !== 32'h200 || o_mem_be !== 4'b1100 || o_mem_wdata !== 32'hABCD_ABCD ||
        o_mem_we !== 1'b1 || o_rdata !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL store_half: addr=%h be=%b wdata=%h we=%b rdata=%h, required 200 1100 abcdabcd 1 ffffff80",
               o_mem_addr, o_mem_be, o_mem_wdata, o_mem_we, o_rdata);
    end
    run_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1);
    run_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1);
  endtask

  task automatic test_timeout();
    run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
    run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h1234_5678, TMO);
    vectors++;
    if (o_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL ack_wins: rdata=%h, required 12345678", o_rdata);
    end
  endtask

  task automatic test_ack_outside_req();
    for (int i = 0; i < 3; i++) begin
      i_mem_ack = 1'b1;
      i_mem_rdata = $urandom();
      step();
      vectors++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL idle_ack: busy=%b done=%b rdata=%h, required 0 0 %h", o_busy, o_done, o_rdata, exp_rdata);
      end
    end
    i_mem_ack = 1'b0;
  endtask

  task automatic test_reset_during_req();
    i_start = 1'b1; i_we = 1'b0; i_size = 2'b10; i_sign_ext = 1'b0; i_addr = 32'h80;
    step();
    i_start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_rdata = 32'h0;
    vectors++;
    if (o_mem_req !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_rdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: req=%b busy=%b done=%b rdata=%h, required 0 0 0 0", o_mem_req, o_busy, o_done, o_rdata);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL no_done_after_reset: done=%b busy=%b, required 0 0", o_done, o_busy);
      end
    end
    run_access(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, 32'h9ABC_0000, 1);
    vectors++;
    if (o_rdata !== 32'h0000_9ABC) begin
      errors++;
      $display("FAIL load_after_reset: rdata=%h, required 00009abc", o_rdata);
    end
  endtask

  task automatic test_random();
    int r, tack;
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      tack = (r == 0) ? 0 : (r == 1) ? TMO : (r == 2) ? TMO + 1 : int'($urandom_range(1, 4));
      run_access(1'($urandom()), 2'($urandom()), 1'($urandom()), $urandom(), $urandom(), $urandom(), tack);
      if ($urandom_range(0, 3) == 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_outside_req();
    test_reset_during_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter SIZE, 32, datapath width; only SIZE=32 is supported (4 byte lanes).
REQ-002 Parameter TIMEOUT, 16, number of REQ cycles without mem_ack before abort.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request strobe, sampled only in IDLE.
REQ-006 we  in  1  1=store, 0=load; sampled with start.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 illegal; sampled with start.
REQ-008 sign_ext  in  1  load result sign-extended when 1, zero-extended when 0.
REQ-009 addr  in  SIZE  byte address (ALU rez output).
REQ-010 wdata  in  SIZE  store data (register-file rd2); low bits used for byte/half.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 rdata  out  SIZE  registered, extended load result.
REQ-014 misalign  out  1  valid with done; access misaligned or size=11.
REQ-015 timeout  out  1  valid with done; memory failed to acknowledge.
REQ-016 mem_req, mem_we  out  1 each  memory request and write enable.
REQ-017 mem_addr  out  SIZE  {addr[31:2],2'b00}.
REQ-018 mem_wdata  out  SIZE  lane-replicated store data.
REQ-019 mem_be  out  4  byte enables, bit n = byte lane n (little-endian).
REQ-020 mem_ack  in  1  memory accepts/completes request this cycle.
REQ-021 mem_rdata  in  SIZE  read word, valid when mem_ack=1.

Function
REQ-022 States SHALL be IDLE, REQ, RESP; IDLE+start -> REQ if aligned, else RESP with misalign=1, no memory request.
REQ-023 Misaligned SHALL mean size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11.
REQ-024 In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_be/mem_wdata held stable from captured values until mem_ack.
REQ-025 REQ+mem_ack -> RESP; loads capture extended lane into rdata on that edge.
REQ-026 RESP SHALL assert done for exactly one cycle then return to IDLE; misalign/timeout cleared in IDLE.
REQ-027 Latency: start at cycle 0, mem_req from cycle 1, mem_ack at cycle k>=1, done at cycle k+1; misaligned done at cycle 1.
REQ-028 An 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; reaching TIMEOUT -> RESP with timeout=1, mem_req dropped, rdata unchanged.
REQ-029 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-030 start while busy SHALL be ignored; mem_ack outside REQ SHALL be ignored.
REQ-031 mem_be: byte 1<<addr[1:0]; half 4'b0011 (addr[1]=0) or 4'b1100; word 4'b1111.
REQ-032 mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-033 Load extraction SHALL select the lane by addr[1:0] and extend to SIZE per captured sign_ext; stores SHALL not alter rdata.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and busy, done, misalign, timeout, mem_req, mem_we, mem_be, counter to 0, mem_addr, mem_wdata, rdata to 0.
REQ-035 Reset during REQ SHALL abandon the transaction with no done pulse; first start after release is served normally.

Structure
REQ-036 Shared package SHALL hold the state enum, size codes (SZ_BYTE, SZ_HALF, SZ_WORD), and TIMEOUT default.
REQ-037 One combinational sub-module lane_extract SHALL perform lane select and sign/zero extension; FSM, counter and byte-enable logic stay in mem_access_unit.

Verification
REQ-038 Load byte addr=0x103, sign_ext=1, mem_rdata=0x80FF_1234, ack at cycle 2 -> mem_be=1000, done at cycle 3, rdata=0xFFFF_FF80.
REQ-039 Store half addr=0x202, wdata=0x0000_ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, rdata unchanged.
REQ-040 Load word addr=0x101 -> done at cycle 1 with misalign=1, mem_req never asserted; size=11 at addr=0 gives the same.
REQ-041 Load word, mem_ack never asserted -> mem_req high exactly 16 cycles, then done with timeout=1; repeat with ack on 16th cycle -> timeout=0, rdata captured.
REQ-042 rst_n pulsed low during REQ -> mem_req falls asynchronously, no done; subsequent load half addr=0x2, sign_ext=0, mem_rdata=0x9ABC_0000 -> rdata=0x0000_9ABC.
